// File: rtl/user_obi_copy_mgr.sv
// OBI manager for the user domain: copies a block of 32-bit words from a source
// to a destination address, one outstanding bus transaction at a time.
module user_obi_copy_mgr #(
   parameter int LenWidth = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [31:0]         src_addr_i,
   input  logic [31:0]         dst_addr_i,
   input  logic [LenWidth-1:0] len_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                error_o,
   output logic                obi_req_o,
   input  logic                obi_gnt_i,
   output logic [31:0]         obi_addr_o,
   output logic                obi_we_o,
   output logic [3:0]          obi_be_o,
   output logic [31:0]         obi_wdata_o,
   input  logic                obi_rvalid_i,
   input  logic [31:0]         obi_rdata_i,
   input  logic                obi_err_i
);

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_RSP,
      WR_REQ,
      WR_RSP,
      FINISH
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         src_q, src_d;
   logic [31:0]         dst_q, dst_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [LenWidth-1:0] remaining_q, remaining_d;
   logic                error_q, error_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         src_q       <= '0;
         dst_q       <= '0;
         wdata_q     <= '0;
         remaining_q <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         wdata_q     <= wdata_d;
         remaining_q <= remaining_d;
         error_q     <= error_d;
      end
   end

   // Responses are only consumed in the two *_RSP states; a stray rvalid elsewhere falls through.
   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      dst_d       = dst_q;
      wdata_d     = wdata_q;
      remaining_d = remaining_q;
      error_d     = error_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               src_d       = src_addr_i;
               dst_d       = dst_addr_i;
               remaining_d = len_i;
               error_d     = 1'b0;
               if ((src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00)) begin
                  error_d = 1'b1;
                  state_d = FINISH;
               end else if (len_i == '0) begin
                  state_d = FINISH;
               end else begin
                  state_d = RD_REQ;
               end
            end
         end
         RD_REQ: begin
            if (obi_gnt_i) state_d = RD_RSP;
         end
         RD_RSP: begin
            if (obi_rvalid_i) begin
               if (obi_err_i) begin
                  error_d = 1'b1;
                  state_d = FINISH;
               end else begin
                  wdata_d = obi_rdata_i;
                  state_d = WR_REQ;
               end
            end
         end
         WR_REQ: begin
            if (obi_gnt_i) state_d = WR_RSP;
         end
         WR_RSP: begin
            if (obi_rvalid_i) begin
               if (obi_err_i) begin
                  error_d = 1'b1;
                  state_d = FINISH;
               end else begin
                  src_d       = src_q + 32'd4;
                  dst_d       = dst_q + 32'd4;
                  remaining_d = remaining_q - LenWidth'(1);
                  state_d     = (remaining_q == LenWidth'(1)) ? FINISH : RD_REQ;
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign obi_req_o   = (state_q == RD_REQ) || (state_q == WR_REQ);
   assign obi_we_o    = (state_q == WR_REQ);
   assign obi_addr_o  = (state_q == RD_REQ) ? src_q :
                        (state_q == WR_REQ) ? dst_q : 32'd0;
   assign obi_be_o    = 4'b1111;
   assign obi_wdata_o = wdata_q;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == FINISH);
   assign error_o     = error_q;

endmodule
